// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per clock.
// Optional SEQ_DIVIDER_EARLY_OUT_EN skips the dividend's leading zeros.
`default_nettype none

module seq_divider #(
    parameter int DVD_W = 32,
    parameter int DVR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVR_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVD_W-1:0] quotient,
    output logic [DVR_W-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);
    localparam int         CNT_W  = $clog2(DVD_W + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [DVD_W-1:0] r_q;
    logic [DVR_W-1:0] r_r;
    logic [DVR_W-1:0] r_dvr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dbz;

    logic             w_accept;
    logic             w_release;
    logic             w_last;
    logic [DVR_W:0]   w_t;
    logic [DVR_W:0]   w_diff;
    logic             w_ge;
    logic [DVD_W-1:0] w_load_q;
    logic [CNT_W-1:0] w_load_cnt;

    assign w_accept  = in_valid && in_ready;
    assign w_release = out_valid && out_ready;
    assign w_last    = (r_cnt == '0);

    // Trial value is one bit wider than the divisor so it never truncates.
    assign w_t    = {r_r, r_q[DVD_W-1]};
    assign w_ge   = (w_t >= {1'b0, r_dvr});
    assign w_diff = w_t - {1'b0, r_dvr};

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    logic [CNT_W-1:0] w_lz;

    always_comb begin
        w_lz = CNT_W'(DVD_W);
        for (int i = 0; i < DVD_W; i++) begin
            if (dividend[i]) w_lz = CNT_W'(DVD_W - 1 - i);
        end
    end

    // A zero dividend still runs one iteration on Q=0, which yields 0 r 0.
    assign w_load_q   = dividend << w_lz;
    assign w_load_cnt = (w_lz == CNT_W'(DVD_W)) ? '0 : CNT_W'(DVD_W - 1) - w_lz;
`else
    assign w_load_q   = dividend;
    assign w_load_cnt = CNT_W'(DVD_W - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next = S_BUSY;
            S_BUSY:  if (w_last)    w_next = S_DONE;
            S_DONE:  if (w_release) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        busy      = (r_state == S_BUSY);
        out_valid = (r_state == S_DONE);
    end

    // Zero divisor preloads the final result and spends one idle BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_r   <= '0;
            r_dvr <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dvr <= divisor;
                        r_dbz <= (divisor == '0);
                        if (divisor == '0) begin
                            r_q   <= '1;
                            r_r   <= dividend[DVR_W-1:0];
                            r_cnt <= '0;
                        end else begin
                            r_q   <= w_load_q;
                            r_r   <= '0;
                            r_cnt <= w_load_cnt;
                        end
                    end
                end
                S_BUSY: begin
                    if (!r_dbz) begin
                        r_r <= DVR_W'(w_ge ? w_diff : w_t);
                        r_q <= {r_q[DVD_W-2:0], w_ge};
                    end
                    if (!w_last) r_cnt <= r_cnt - 1'b1;
                end
                S_DONE: begin
                    if (w_release) r_dbz <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_q;
    assign remainder   = r_r;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table vectors, hand-written corner sequences and randomized
// operations checked against an arithmetic reference model.
`default_nettype none

module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.DVD_W(32), .DVR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
        int          stall;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: plain integer division; latency from the number of significant dividend bits.
    task automatic model(input logic [31:0] a, input logic [15:0] b,
                         output logic [31:0] q, output logic [15:0] r,
                         output logic dbz, output int lat);
        int nbits = 0;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a[15:0]; dbz = 1'b1; lat = 1;
        end else begin
            q = a / b; r = 16'(a % b); dbz = 1'b0;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
            while (nbits < 32 && (a >> nbits) != 0) nbits++;
            lat = (nbits < 1) ? 1 : nbits;
`else
            lat = 32;
`endif
        end
    endtask

    task automatic do_op(input string nm, input vec_t v, input logic junk);
        int lat = 0;
        int w = 0;
        while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
        check({nm, " in_ready before accept"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        dividend  = v.a;
        divisor   = v.b;
        out_ready = (v.stall == 0);
        @(posedge clk); #1;
        in_valid = junk;
        dividend = $urandom;
        divisor  = 16'($urandom);
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check({nm, " latency"}, 64'(lat), 64'(v.lat));
        check({nm, " quotient"}, 64'(quotient), 64'(v.q));
        check({nm, " remainder"}, 64'(remainder), 64'(v.r));
        check({nm, " div_by_zero"}, 64'(div_by_zero), 64'(v.dbz));
        for (int i = 0; i < v.stall; i++) begin
            @(posedge clk); #1;
            check({nm, " held"}, {out_valid, in_ready, div_by_zero, quotient, remainder},
                  {1'b1, 1'b0, v.dbz, v.q, v.r});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({nm, " after handshake"}, {out_valid, in_ready, div_by_zero}, {1'b0, 1'b1, 1'b0});
        out_ready = 1'b0;
    endtask

    vec_t tbl[9];

    initial begin
        vec_t v;
        int e5, e0;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        e5 = 3; e0 = 1;
`else
        e5 = 32; e0 = 32;
`endif
        tbl[0] = '{32'd100,        16'd7,      32'd14,         16'd2,      1'b0, 32, 0};
        tbl[1] = '{32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001,  16'd0,      1'b0, 32, 0};
        tbl[2] = '{32'hFFFF_FFFF,  16'd1,      32'hFFFF_FFFF,  16'd0,      1'b0, 32, 0};
        tbl[3] = '{32'h1234_5678,  16'd0,      32'hFFFF_FFFF,  16'h5678,   1'b1, 1,  0};
        tbl[4] = '{32'd9,          16'd4,      32'd2,          16'd1,      1'b0, 32, 0};
        tbl[5] = '{32'd5,          16'd2,      32'd2,          16'd1,      1'b0, e5, 0};
        tbl[6] = '{32'd0,          16'd7,      32'd0,          16'd0,      1'b0, e0, 0};
        tbl[7] = '{32'd1000,       16'd3,      32'd333,        16'd1,      1'b0, 32, 10};
        tbl[8] = '{32'd9,          16'd4,      32'd2,          16'd1,      1'b0, 32, 0};
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        tbl[4].lat = 4; tbl[7].lat = 10; tbl[8].lat = 4;
        tbl[1].lat = 32; tbl[2].lat = 32; tbl[0].lat = 7;
`endif

        #12;
        check("reset outputs", {in_ready, out_valid, busy, div_by_zero, quotient, remainder},
              {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0});
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) do_op($sformatf("vec%0d", i), tbl[i], (i == 7));

        // Reset in the middle of 50000/9, then rerun it.
        in_valid = 1'b1; dividend = 32'd50000; divisor = 16'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("mid reset", {out_valid, in_ready, busy}, {1'b0, 1'b1, 1'b0});
        @(posedge clk); #2 rst_n = 1'b1;
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 40; i++) begin @(posedge clk); #1; seen |= out_valid; end
            check("no result after reset", 64'(seen), 64'd0);
        end
        v = '{32'd50000, 16'd9, 32'd5555, 16'd5, 1'b0, 32, 0};
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
        v.lat = 16;
`endif
        do_op("rerun 50000/9", v, 1'b0);

        for (int n = 0; n < 150; n++) begin
            int m = $urandom_range(0, 15);
            v.a = (m < 4) ? 32'($urandom_range(0, 300)) : $urandom;
            v.b = (m == 0) ? 16'd0 : (m < 6) ? 16'($urandom_range(1, 15)) : 16'($urandom);
            v.stall = $urandom_range(0, 3);
            model(v.a, v.b, v.q, v.r, v.dbz, v.lat);
            do_op($sformatf("rand%0d %0h/%0h", n, v.a, v.b), v, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
